// File: rtl/ram_burst_master.sv
// ram_burst_master: turns one burst command into word writes/reads on the single-port RAM port.
// Optional feature: define RAM_MASTER_BOUNDS_EN to reject commands whose BASE+LEN crosses 2**AW.
module ram_burst_master #(
  parameter int AW     = 14,
  parameter int DW     = 22,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          cmd_we,
  input  logic [AW-1:0] base,
  input  logic [AW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic          err,
  input  logic [DW-1:0] wd,
  input  logic          wd_valid,
  output logic          wd_ready,
  output logic [DW-1:0] rdata,
  output logic          rvalid,
  output logic [AW-1:0] ram_a,
  output logic [DW-1:0] ram_d,
  output logic          ram_rd,
  output logic          ram_wr,
  input  logic [DW-1:0] ram_s,
  output logic [2:0]    dbg_state
);

  // Handshakes: wd is consumed on a rising edge where wd_valid & wd_ready are both 1;
  // rvalid qualifies rdata for exactly one cycle per word and cannot be stalled.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     addr_q, cnt_q, len_q;
  logic [RD_LAT-1:0] tag_q;
  logic              reject, accept, wr_hs, last, pending;

`ifdef RAM_MASTER_BOUNDS_EN
  logic [AW:0] end_addr;
  logic        err_q;

  // A carry out of the AW-bit sum means the burst would wrap past the top address.
  assign end_addr = {1'b0, base} + {1'b0, len};
  assign reject   = end_addr[AW];
  assign err      = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= (state_q == S_IDLE) && start && reject;
  end
`else
  assign reject = 1'b0;
  assign err    = 1'b0;
`endif

  assign accept    = (state_q == S_IDLE) && start && !reject;
  assign wd_ready  = (state_q == S_WRITE);
  assign wr_hs     = wd_ready && wd_valid;
  assign last      = (cnt_q == len_q);
  assign pending   = ram_rd || (|tag_q);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = cmd_we ? S_WRITE : S_READ;
      S_WRITE: if (wr_hs && last) state_d = S_DONE;
      S_READ:  if (last) state_d = S_DRAIN;
      // Leave only once nothing is in flight and the final word has just been presented.
      S_DRAIN: if (!pending && rvalid) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Read-return tags: a 1 enters with every issued read and emerges RD_LAT cycles later.
  generate
    if (RD_LAT == 1) begin : g_tag1
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tag_q <= '0;
        else        tag_q <= ram_rd;
      end
    end else begin : g_tagn
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tag_q <= '0;
        else        tag_q <= {tag_q[RD_LAT-2:0], ram_rd};
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      cnt_q  <= '0;
      len_q  <= '0;
      ram_a  <= '0;
      ram_d  <= '0;
      ram_rd <= 1'b0;
      ram_wr <= 1'b0;
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      ram_rd <= 1'b0;
      ram_wr <= 1'b0;
      rvalid <= tag_q[RD_LAT-1];
      if (tag_q[RD_LAT-1]) rdata <= ram_s;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            addr_q <= base;
            len_q  <= len;
            cnt_q  <= '0;
          end
        end
        S_WRITE: begin
          if (wr_hs) begin
            ram_wr <= 1'b1;
            ram_a  <= addr_q;
            ram_d  <= wd;
            addr_q <= addr_q + AW'(1);
            cnt_q  <= cnt_q + AW'(1);
          end
        end
        S_READ: begin
          ram_rd <= 1'b1;
          ram_a  <= addr_q;
          addr_q <= addr_q + AW'(1);
          cnt_q  <= cnt_q + AW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_burst_master.sv
// Bench for ram_burst_master: command table plus random bursts, checked against a word-level
// RAM reference model and expected queues for every RAM-port and read-stream event.
`timescale 1ns/1ps
module tb_ram_burst_master;
  localparam int AW     = 14;
  localparam int DW     = 22;
  localparam int RD_LAT = 1;
  localparam int DEPTH  = 1 << AW;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, cmd_we = 1'b0, wd_valid = 1'b0;
  logic [AW-1:0] base = '0, len = '0;
  logic [DW-1:0] wd = '0;
  logic          busy, done, err, wd_ready, rvalid, ram_rd, ram_wr;
  logic [DW-1:0] rdata, ram_d, ram_s;
  logic [AW-1:0] ram_a;
  logic [2:0]    dbg_state;

  ram_burst_master #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cmd_we(cmd_we), .base(base), .len(len),
    .busy(busy), .done(done), .err(err), .wd(wd), .wd_valid(wd_valid), .wd_ready(wd_ready),
    .rdata(rdata), .rvalid(rvalid), .ram_a(ram_a), .ram_d(ram_d), .ram_rd(ram_rd),
    .ram_wr(ram_wr), .ram_s(ram_s), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- RAM macro (synchronous read, one cycle) ----------------
  logic [DW-1:0] ram_mem [DEPTH];
  always @(posedge clk) begin
    if (ram_wr) ram_mem[ram_a] <= ram_d;
    if (ram_rd) ram_s <= ram_mem[ram_a];
  end

  // ---------------- reference model and scoreboard ----------------
  logic [DW-1:0] ref_mem [DEPTH];
  logic [31:0]   exp_wa_q[$], exp_wd_q[$], exp_wc_q[$];
  logic [31:0]   exp_ra_q[$], exp_rc_q[$], exp_rv_q[$], exp_vc_q[$];
  int            done_q[$];
  logic [DW-1:0] obs_rd_q[$];
  int            n_vec = 0, n_err = 0;
  bit            mon_en = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (ram_wr) begin
        chk("rd_wr_exclusive", {31'b0, ram_rd}, 0);
        if (exp_wc_q.size() == 0 || exp_wa_q.size() == 0) chk("unexpected_ram_wr", 1, 0);
        else begin
          chk("ram_wr_cycle", cyc, exp_wc_q.pop_front());
          chk("ram_wr_addr", ram_a, exp_wa_q.pop_front());
          chk("ram_wr_data", ram_d, exp_wd_q.pop_front());
        end
      end
      if (ram_rd) begin
        if (exp_rc_q.size() == 0) chk("unexpected_ram_rd", 1, 0);
        else begin
          chk("ram_rd_cycle", cyc, exp_rc_q.pop_front());
          chk("ram_rd_addr", ram_a, exp_ra_q.pop_front());
        end
      end
      if (rvalid) begin
        obs_rd_q.push_back(rdata);
        if (exp_vc_q.size() == 0) chk("unexpected_rvalid", 1, 0);
        else begin
          chk("rvalid_cycle", cyc, exp_vc_q.pop_front());
          chk("rdata", rdata, exp_rv_q.pop_front());
        end
      end
      if (done) done_q.push_back(cyc);
    end
  end

  // ---------------- driver ----------------
  task automatic do_cmd(input bit we, input int b, input int l, input int gap, input int dbase,
                        input bit poke, input bit chk_d0, input int exp_d0);
    int            c0, last_hs, sent, k, exp_done, waited;
    logic [AW-1:0] a;
    logic [DW-1:0] data[$];
    bit            rej;
    rej      = 1'b0;
    last_hs  = -100;
    exp_done = -100;
`ifdef RAM_MASTER_BOUNDS_EN
    rej = (b + l) >= DEPTH;
`endif
    obs_rd_q.delete();
    @(posedge clk); #1;
    c0 = cyc;
    if (!rej) begin
      for (int i = 0; i <= l; i++) begin
        a = AW'(b + i);
        if (we) begin
          data.push_back(dbase >= 0 ? DW'(dbase + i) : DW'($urandom));
          exp_wa_q.push_back(32'(a));
          exp_wd_q.push_back(32'(data[i]));
          ref_mem[a] = data[i];
        end else begin
          exp_ra_q.push_back(32'(a));
          exp_rc_q.push_back(c0 + 2 + i);
          exp_rv_q.push_back(32'(ref_mem[a]));
          exp_vc_q.push_back(c0 + 3 + RD_LAT + i);
        end
      end
      exp_done = c0 + 4 + RD_LAT + l;
    end
    start = 1'b1; cmd_we = we; base = AW'(b); len = AW'(l);
    @(posedge clk); #1;
    // Command fields are scrambled after the accepting edge; they must not matter any more.
    start = 1'b0; cmd_we = 1'($urandom); base = AW'($urandom); len = AW'($urandom);
    if (rej) begin
      @(negedge clk);
      chk("err_pulse", err, 1);
      chk("busy_after_reject", busy, 0);
      @(negedge clk);
      chk("err_one_cycle", err, 0);
      return;
    end
    if (we) begin
      sent = 0; k = 0;
      while (sent <= l && k < 400) begin
        wd_valid = (gap == 0) ? 1'b1 : (gap == 1) ? ((k % 2) == 0) : 1'($urandom_range(0, 1));
        wd = data[sent];
        @(negedge clk);
        chk("wd_ready", wd_ready, 1);
        if (wd_valid) begin
          exp_wc_q.push_back(cyc + 1);
          last_hs = cyc;
          sent++;
        end
        @(posedge clk); #1;
        k++;
      end
      wd_valid = 1'b0; wd = DW'($urandom);
      exp_done = last_hs + 1;
    end else if (poke) begin
      @(posedge clk); #1;
      start = 1'b1; cmd_we = 1'b1; base = AW'('h200); len = AW'(5);
      @(negedge clk);
      chk("busy_at_poke", busy, 1);
      @(posedge clk); #1;
      start = 1'b0;
    end
    waited = 0;
    while (done_q.size() == 0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (done_q.size() == 0) chk("done_timeout", 0, 1);
    else chk("done_cycle", done_q.pop_front(), exp_done);
    repeat (3) @(negedge clk);
    chk("single_done", done_q.size(), 0);
    chk("idle_after_done", busy, 0);
    chk("wd_ready_idle", wd_ready, 0);
    chk("err_low", err, 0);
    chk("exp_queues_empty", exp_wc_q.size() + exp_wa_q.size() + exp_rc_q.size()
                            + exp_ra_q.size() + exp_vc_q.size() + exp_rv_q.size(), 0);
    if (chk_d0 && !we) begin
      if (obs_rd_q.size() == 0) chk("first_rdata_missing", 0, 1);
      else chk("first_rdata", obs_rd_q[0], exp_d0);
    end
  endtask

  // ---------------- stimulus table ----------------
  typedef struct {
    bit we; int base; int len; int gap; int dbase; bit poke; bit chk_d0; int exp_d0;
  } vec_t;
  vec_t vecs[8];
  int   wr_b_q[$], wr_l_q[$];

  initial begin
    int  b, l, idx, off;
    bit  we;
    vecs[0] = '{1'b1, 'h10,   3, 0, 'hAAA, 1'b0, 1'b0, 0};
    vecs[1] = '{1'b1, 'h20,   3, 1, 'hBB0, 1'b0, 1'b0, 0};
    vecs[2] = '{1'b0, 'h10,   3, 0, -1,    1'b0, 1'b1, 'hAAA};
    vecs[3] = '{1'b0, 'h20,   3, 0, -1,    1'b1, 1'b1, 'hBB0};
    vecs[4] = '{1'b1, 'h30,   0, 2, 'h155, 1'b0, 1'b0, 0};
    vecs[5] = '{1'b0, 'h30,   0, 0, -1,    1'b0, 1'b1, 'h155};
    vecs[6] = '{1'b1, 'h3FFE, 3, 0, 'h300, 1'b0, 1'b0, 0};
    vecs[7] = '{1'b0, 'h3FFE, 3, 0, -1,    1'b0, 1'b1, 'h300};

    // Reset values
    #12;
    chk("rst_busy", busy, 0);     chk("rst_done", done, 0);   chk("rst_err", err, 0);
    chk("rst_ram_wr", ram_wr, 0); chk("rst_ram_rd", ram_rd, 0);
    chk("rst_rvalid", rvalid, 0); chk("rst_wd_ready", wd_ready, 0);
    #2 rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      do_cmd(vecs[i].we, vecs[i].base, vecs[i].len, vecs[i].gap, vecs[i].dbase,
             vecs[i].poke, vecs[i].chk_d0, vecs[i].exp_d0);

    // Reset in the middle of a read burst
    mon_en = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; cmd_we = 1'b0; base = AW'('h10); len = AW'(3);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); @(posedge clk); #3;
    chk("rd_active_before_reset", ram_rd, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_ram_rd", ram_rd, 0); chk("arst_ram_wr", ram_wr, 0);
    chk("arst_ram_a", ram_a, 0);   chk("arst_ram_d", ram_d, 0);
    chk("arst_rdata", rdata, 0);   chk("arst_rvalid", rvalid, 0);
    chk("arst_busy", busy, 0);     chk("arst_done", done, 0);
    done_q.delete();
    @(negedge clk); @(negedge clk); #2;
    rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (6) @(negedge clk);
    chk("no_done_after_abort", done_q.size(), 0);
    chk("idle_after_abort", busy, 0);
    chk("quiet_after_abort", {30'b0, ram_rd, rvalid}, 0);

    // Random bursts; reads revisit regions written earlier so the RAM contents are known
    for (int n = 0; n < 30; n++) begin
      we = (wr_b_q.size() == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (we) begin
        b = ($urandom_range(0, 3) == 0) ? $urandom_range(DEPTH - 6, DEPTH - 1)
                                        : $urandom_range(0, DEPTH - 1);
        l = $urandom_range(0, 12);
        do_cmd(1'b1, b, l, 2, -1, 1'b0, 1'b0, 0);
`ifdef RAM_MASTER_BOUNDS_EN
        if (b + l < DEPTH) begin wr_b_q.push_back(b); wr_l_q.push_back(l); end
`else
        wr_b_q.push_back(b); wr_l_q.push_back(l);
`endif
      end else begin
        idx = $urandom_range(0, wr_b_q.size() - 1);
        off = $urandom_range(0, wr_l_q[idx]);
        l   = $urandom_range(0, wr_l_q[idx] - off);
        do_cmd(1'b0, (wr_b_q[idx] + off) % DEPTH, l, 0, -1, 1'b0, 1'b0, 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
